// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUN/PAUSE FSM, 100 Hz tick, lap strobes, display select.
// Optional lap auto-view with timed hold is enabled by defining SW_LAP_AUTOVIEW_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 500000,
    parameter int DEBOUNCE   = 1000000,
    parameter int HOLD_TICKS = 200
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       btn_view,
    output logic       tick,
    output logic       clear,
    output logic       lap_wr,
    output logic [1:0] lap_slot,
    output logic [1:0] lap_count,
    output logic       lap_full,
    output logic [1:0] disp_sel,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    // Button index: 0 start, 1 lap, 2 clear, 3 view
    logic [3:0]      btn_raw, sync_a, sync_b, level, press;
    logic [DB_W-1:0] db_cnt [4];

    assign btn_raw = {btn_view, btn_clear, btn_lap, btn_start};

    always_ff @(posedge clk_50M) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            level  <= '0;
            press  <= '0;
            // NOTE: the counter array is small and must restart cleanly, so it is reset like ordinary flops.
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            press  <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_b[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync_b[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic start_ev, lap_ev, clr_ev, view_ev;
    assign start_ev = press[0];
    assign lap_ev   = press[1];
    assign clr_ev   = press[2];
    assign view_ev  = press[3];

    state_t           state_q, state_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic             tick_nxt, clear_nxt, lap_wr_nxt;
    logic [1:0]       slot_nxt, count_nxt, disp_nxt;

`ifdef SW_LAP_AUTOVIEW_EN
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    logic [HOLD_W-1:0] hold_q, hold_nxt;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nxt  = state_q;
        clear_nxt  = 1'b0;
        lap_wr_nxt = 1'b0;
        slot_nxt   = lap_slot;
        count_nxt  = lap_count;
        disp_nxt   = disp_sel;
`ifdef SW_LAP_AUTOVIEW_EN
        hold_nxt   = hold_q;
`endif

        // Clear outranks start, start outranks lap; losers are dropped
        case (state_q)
            IDLE: begin
                if (clr_ev)        clear_nxt = 1'b1;
                else if (start_ev) state_nxt = RUN;
            end
            RUN: begin
                if (start_ev) begin
                    state_nxt = PAUSE;
                end else if (lap_ev && !lap_full) begin
                    lap_wr_nxt = 1'b1;
                    slot_nxt   = lap_count + 2'd1;
                    count_nxt  = lap_count + 2'd1;
                end
            end
            PAUSE: begin
                if (clr_ev) begin
                    clear_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (start_ev) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clear_nxt)           div_nxt = '0;
        else if (state_q == RUN) div_nxt = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        else                     div_nxt = div_q;
        tick_nxt = (state_nxt == RUN) && (div_nxt == DIV_LAST);

`ifdef SW_LAP_AUTOVIEW_EN
        if (tick && hold_q != '0) begin
            hold_nxt = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) disp_nxt = 2'd0;
        end
`endif
        if (view_ev) begin
            disp_nxt = (disp_sel >= lap_count) ? 2'd0 : disp_sel + 2'd1;
`ifdef SW_LAP_AUTOVIEW_EN
            hold_nxt = '0;
`endif
        end
`ifdef SW_LAP_AUTOVIEW_EN
        if (lap_wr_nxt) begin
            disp_nxt = slot_nxt;
            hold_nxt = HOLD_W'(HOLD_TICKS);
        end
`endif
        if (clear_nxt) begin
            count_nxt = 2'd0;
            disp_nxt  = 2'd0;
`ifdef SW_LAP_AUTOVIEW_EN
            hold_nxt  = '0;
`endif
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            tick      <= 1'b0;
            clear     <= 1'b0;
            lap_wr    <= 1'b0;
            lap_slot  <= 2'd0;
            lap_count <= 2'd0;
            lap_full  <= 1'b0;
            disp_sel  <= 2'd0;
            running   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            div_q     <= div_nxt;
            tick      <= tick_nxt;
            clear     <= clear_nxt;
            lap_wr    <= lap_wr_nxt;
            lap_slot  <= slot_nxt;
            lap_count <= count_nxt;
            lap_full  <= (count_nxt == 2'd3);
            disp_sel  <= disp_nxt;
            running   <= (state_nxt == RUN);
        end
    end

`ifdef SW_LAP_AUTOVIEW_EN
    always_ff @(posedge clk_50M) begin
        if (!reset_n) hold_q <= '0;
        else          hold_q <= hold_nxt;
    end
`endif

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// compared every cycle against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV   = 10;
    localparam int DEBOUNCE   = 4;
    localparam int HOLD_TICKS = 3;

    logic       clk_50M = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0, btn_view = 1'b0;
    logic       tick, clear, lap_wr, lap_full, running;
    logic [1:0] lap_slot, lap_count, disp_sel, state;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk_50M(clk_50M), .reset_n(reset_n),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear), .btn_view(btn_view),
        .tick(tick), .clear(clear), .lap_wr(lap_wr), .lap_slot(lap_slot),
        .lap_count(lap_count), .lap_full(lap_full), .disp_sel(disp_sel),
        .running(running), .state(state)
    );

    always #5 clk_50M = ~clk_50M;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: button index 0 start, 1 lap, 2 clear, 3 view
    int m_s1[4], m_s2[4], m_lvl[4], m_mis[4];
    bit m_ev[4];
    int m_state, m_count, m_slot, m_disp, m_hold, m_runcyc;
    bit m_tick, m_clear, m_lapwr;

    task automatic model_edge();
        bit raw[4];
        bit ev[4];
        bit old_tick;
        int old_disp, old_count;
        raw[0] = btn_start; raw[1] = btn_lap; raw[2] = btn_clear; raw[3] = btn_view;
        for (int i = 0; i < 4; i++) ev[i] = m_ev[i];
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_mis[i] = 0; m_ev[i] = 0;
            end
            m_state = 0; m_count = 0; m_slot = 0; m_disp = 0; m_hold = 0; m_runcyc = 0;
            m_tick = 0; m_clear = 0; m_lapwr = 0;
            return;
        end
        // A new level is accepted after DEBOUNCE consecutive differing samples
        for (int i = 0; i < 4; i++) begin
            m_ev[i] = 0;
            if (m_s2[i] != m_lvl[i]) begin
                m_mis[i]++;
                if (m_mis[i] == DEBOUNCE) begin
                    m_lvl[i] = m_s2[i];
                    m_mis[i] = 0;
                    m_ev[i]  = (m_lvl[i] == 1);
                end
            end else begin
                m_mis[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        old_tick = m_tick; old_disp = m_disp; old_count = m_count;
        m_clear = 0; m_lapwr = 0;
        case (m_state)
            0: if (ev[2]) m_clear = 1; else if (ev[0]) m_state = 1;
            1: if (ev[0]) m_state = 2;
               else if (ev[1] && m_count < 3) begin m_lapwr = 1; m_count++; m_slot = m_count; end
            default: if (ev[2]) begin m_clear = 1; m_state = 0; end else if (ev[0]) m_state = 1;
        endcase
`ifdef SW_LAP_AUTOVIEW_EN
        if (old_tick && m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_disp = 0;
        end
`endif
        if (ev[3]) begin
            m_disp = (old_disp >= old_count) ? 0 : old_disp + 1;
            m_hold = 0;
        end
`ifdef SW_LAP_AUTOVIEW_EN
        if (m_lapwr) begin m_disp = m_slot; m_hold = HOLD_TICKS; end
`endif
        if (m_clear) begin m_count = 0; m_disp = 0; m_hold = 0; m_runcyc = 0; end
        // A tick falls on every TICK_DIV-th RUN cycle counted since the last clear
        if (m_state == 1) m_runcyc++;
        m_tick = (m_state == 1) && (m_runcyc % TICK_DIV == 0);
    endtask

    function automatic logic [12:0] exp_vec();
        return {2'(m_state), m_state == 1, m_tick, m_clear, m_lapwr, 2'(m_slot),
                2'(m_count), m_count == 3, 2'(m_disp)};
    endfunction

    logic [12:0] dut_vec;
    assign dut_vec = {state, running, tick, clear, lap_wr, lap_slot, lap_count, lap_full, disp_sel};

    int n_tick, n_lapwr, n_clear, n_state_chg;
    logic [1:0] prev_state = 2'b00;
    logic [1:0] slots[$];

    task automatic step();
        @(posedge clk_50M);
        model_edge();
        @(negedge clk_50M);
        check("outputs", dut_vec, exp_vec());
        if (tick) n_tick++;
        if (clear) n_clear++;
        if (lap_wr) begin n_lapwr++; slots.push_back(lap_slot); end
        if (state !== prev_state) n_state_chg++;
        prev_state = state;
    endtask

    task automatic drive(input logic [3:0] m);
        btn_start = m[0]; btn_lap = m[1]; btn_clear = m[2]; btn_view = m[3];
    endtask

    task automatic press(input logic [3:0] m);
        drive(m);
        repeat (6) step();
        drive(4'b0000);
        repeat (10) step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, first_tick, k, ticks;
        logic [31:0] sv;

        repeat (3) step();
        check("reset_vec", dut_vec, 13'd0);
        reset_n = 1'b1;
        step();

        // Start press latency and tick phase
        btn_start = 1'b1; lat = 0; n_tick = 0;
        while (state !== 2'b01 && lat < 20) begin step(); lat++; end
        check("start_latency", lat, 7);
        check("running", running, 1'b1);
        check("idle_ticks", n_tick, 0);
        btn_start = 1'b0; first_tick = 0; n_tick = 0;
        for (int c = 2; c <= 30; c++) begin
            step();
            if (tick && first_tick == 0) first_tick = c;
        end
        check("first_tick", first_tick, 10);
        check("tick_count", n_tick, 3);

        // Four laps: only three captured
        n_lapwr = 0; slots.delete();
        repeat (4) press(4'b0010);
        sv = 0;
        foreach (slots[i]) sv = (sv << 2) | 32'(slots[i]);
        check("lap_wr_count", n_lapwr, 3);
        check("lap_slots", sv, 32'h1B);
        check("lap_count", lap_count, 2'd3);
        check("lap_full", lap_full, 1'b1);

        // Pause freezes ticks, clear from pause returns to idle
        press(4'b0001);
        check("pause_state", state, 2'b10);
        n_tick = 0;
        repeat (30) step();
        check("pause_ticks", n_tick, 0);
        n_clear = 0;
        press(4'b0100);
        check("clear_pulses", n_clear, 1);
        check("clear_state", state, 2'b00);
        check("clear_laps", lap_count, 2'd0);

        // Clear is ignored while running
        press(4'b0001);
        check("rerun_state", state, 2'b01);
        n_clear = 0;
        press(4'b0100);
        check("run_clear_pulses", n_clear, 0);
        check("run_clear_state", state, 2'b01);

        // Short glitches rejected, one long press accepted once
        n_state_chg = 0;
        repeat (5) begin
            btn_start = 1'b1; step(); step();
            btn_start = 1'b0; step(); step();
        end
        check("glitch_changes", n_state_chg, 0);
        btn_start = 1'b1; repeat (8) step();
        btn_start = 1'b0; repeat (10) step();
        check("long_press_state", state, 2'b10);
        check("long_press_changes", n_state_chg, 1);

        // Start and lap in the same cycle: start wins
        press(4'b0100);
        press(4'b0001);
        n_lapwr = 0;
        press(4'b0011);
        check("sim_state", state, 2'b10);
        check("sim_lap_wr", n_lapwr, 0);

`ifndef SW_LAP_AUTOVIEW_EN
        press(4'b0001);
        press(4'b0010);
        press(4'b0010);
        press(4'b0001);
        press(4'b1000);
        check("view_1", disp_sel, 2'd1);
        press(4'b1000);
        check("view_2", disp_sel, 2'd2);
        press(4'b1000);
        check("view_0", disp_sel, 2'd0);
`endif

        // Reset mid-run
        press(4'b0001);
        check("pre_reset_state", state, 2'b01);
        repeat (5) step();
        reset_n = 1'b0;
        step();
        check("reset_mid_vec", dut_vec, 13'd0);
        reset_n = 1'b1;
        step();

`ifdef SW_LAP_AUTOVIEW_EN
        press(4'b0001);
        btn_lap = 1'b1; k = 0;
        while (!lap_wr && k < 20) begin step(); k++; end
        btn_lap = 1'b0;
        check("auto_lap_wr", lap_wr, 1'b1);
        check("auto_disp", disp_sel, 2'd1);
        ticks = 0; k = 0;
        while (disp_sel == 2'd1 && k < 200) begin
            if (tick) ticks++;
            step(); k++;
        end
        check("auto_hold_ticks", ticks, 3);
        check("auto_disp_back", disp_sel, 2'd0);
`endif

        // Random button traffic against the model
        for (int it = 0; it < 200; it++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) m = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0; step(); reset_n = 1'b1;
            end
            drive(m);
            repeat ($urandom_range(1, 9)) step();
            drive(4'b0000);
            repeat ($urandom_range(1, 12)) step();
        end
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
